cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 3, meaning opcode field width (instruction bits 15:13).
REQ-002 SHALL have clk  input  1  rising-edge system clock.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have run  input  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary.
REQ-005 SHALL have opcode  input  OPW  instruction-register bits 15:13, valid from the DECODE state onward.
REQ-006 SHALL have beq_eq  input  1  ALU equality flag for the BEQ operand compare, sampled in EXEC.
REQ-007 SHALL have mem_ack  input  1  memory completion; read data is valid in the same cycle.
REQ-008 SHALL have mem_req  output  1  memory request, held until acknowledged.
REQ-009 SHALL have mem_we  output  1  1 = write (SW data phase only).
REQ-010 SHALL have mem_addr_sel  output  1  0 = PC (fetch), 1 = decoded data address.
REQ-011 SHALL have ir_load  output  1  one-cycle pulse that loads IR.
REQ-012 SHALL have gpr_we  output  1  one-cycle register-file write strobe.
REQ-013 SHALL have pc_en  output  1  one-cycle PC update strobe.
REQ-014 SHALL have pc_sel  output  2  PC source: 00 = PC+1, 01 = PC+1+imm (BEQ), 10 = register (JALR).
REQ-015 SHALL have busy  output  1  1 in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM.
REQ-017 IDLE: when run=1, go to FETCH next cycle; otherwise stay in IDLE.
REQ-018 FETCH: mem_req=1, mem_addr_sel=0, mem_we=0; stay until mem_ack=1, then pulse ir_load in the same cycle and go to DECODE.
REQ-019 DECODE: one cycle with no strobes; go to EXEC.
REQ-020 EXEC for opcodes 000, 001, 010, 011 (ADD/ADDI/NAND/LUI): gpr_we=1, pc_en=1, pc_sel=00.
REQ-021 EXEC for opcode 110 (BEQ): pc_en=1, gpr_we=0; pc_sel=01 if beq_eq=1, else 00.
REQ-022 EXEC for opcode 111 (JALR): gpr_we=1, pc_en=1, pc_sel=10.
REQ-023 EXEC for opcodes 100/101 (SW/LW): no strobes; go to MEM.
REQ-024 MEM: mem_req=1, mem_addr_sel=1; mem_we=1 only for SW.
REQ-025 MEM on mem_ack: pc_en=1 with pc_sel=00; gpr_we=1 only for LW.
REQ-026 Instruction boundary: after EXEC for a non-memory op, or after MEM on ack, go to FETCH if run=1, else IDLE.
REQ-027 mem_ack SHALL be ignored when mem_req=0.
REQ-028 mem_ack in the same cycle as the first mem_req cycle SHALL be accepted (zero-wait memory).
REQ-029 Minimum latency: 3 cycles per ALU/BEQ/JALR instruction, 4 cycles per LW/SW.
REQ-030 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes and the FSM then parks in IDLE.
REQ-031 gpr_we, pc_en and ir_load SHALL each assert for at most one cycle per instruction.
REQ-032 All outputs except pc_sel SHALL be 0 in cycles where they are not specified above; pc_sel is 00 unless pc_en=1.

Reset
REQ-033 rst=1 SHALL force IDLE and drive all outputs to 0 at the next clock edge, overriding any transition including an in-flight memory request.
REQ-034 A mem_ack that arrives after reset for a request issued before reset SHALL be ignored, per REQ-027.

Configuration
REQ-035 With CPU_SEQ_PERF_EN defined, the block SHALL add outputs cycle_cnt[31:0] (increments every cycle while busy=1) and instret[31:0] (increments once per instruction boundary); both wrap at 2^32 and reset to 0.
REQ-036 Without CPU_SEQ_PERF_EN, the counters and their ports SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 The shared package risc16_pkg SHALL hold the state enum, the opcode constants (OP_ADD..OP_JALR) and the pc_sel encodings.
REQ-038 The counters SHALL be a sub-module, cpu_seq_perf, instantiated only under CPU_SEQ_PERF_EN; the FSM itself SHALL stay in one module.

Verification
REQ-039 Test: run=1, opcode=000, mem_ack tied 1 -> ir_load at cycle 1, gpr_we and pc_en (pc_sel=00) at cycle 3, FETCH again at cycle 4.
REQ-040 Test: opcode=101 (LW), data mem_ack delayed 3 cycles -> mem_req and mem_addr_sel=1 held 3 cycles, gpr_we and pc_en on the ack cycle, mem_we=0 throughout.
REQ-041 Test: opcode=110 with beq_eq=1, then with beq_eq=0 -> pc_sel=01, then pc_sel=00; gpr_we=0 in both cases.
REQ-042 Test: run dropped during MEM of an SW -> mem_we=1 until ack, pc_en pulses, then IDLE with busy=0.
REQ-043 Test: rst asserted during FETCH wait, late mem_ack injected after reset -> IDLE with all outputs 0 and no ir_load pulse.
REQ-044 Test (with CPU_SEQ_PERF_EN): 10 ALU instructions with zero-wait memory -> instret=10, cycle_cnt=30.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: sequencer state encoding, opcode constants and
// PC source selects.
package risc16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_REG = 2'b10;

endpackage

// File: rtl/cpu_seq_perf.sv
// Performance counters for the sequencer: busy cycles and retired
// instructions, both free-running and wrapping at 2^32.
module cpu_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy_i,
  input  logic        retire_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_q, instret_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + {31'd0, busy_i};
    instret_d   = instret_q + {31'd0, retire_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RISC16 control sequencer (IDLE/FETCH/DECODE/EXEC/MEM).
// Define CPU_SEQ_PERF_EN to add the cycle_cnt/instret counter outputs.
module cpu_sequencer
  import risc16_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           beq_eq,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_addr_sel,
  output logic           ir_load,
  output logic           gpr_we,
  output logic           pc_en,
  output logic [1:0]     pc_sel,
`ifdef CPU_SEQ_PERF_EN
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instret,
`endif
  output logic           busy
);

  state_t     state_q, state_d;
  logic       retire;
  logic [2:0] op;

  assign op = opcode[2:0];

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    gpr_we       = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEL_INC;
    retire       = 1'b0;
    busy         = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        unique case (op)
          OP_ADD, OP_ADDI, OP_NAND, OP_LUI: begin
            gpr_we = 1'b1;
            pc_en  = 1'b1;
            retire = 1'b1;
          end
          OP_BEQ: begin
            pc_en  = 1'b1;
            pc_sel = beq_eq ? PC_SEL_BR : PC_SEL_INC;
            retire = 1'b1;
          end
          OP_JALR: begin
            gpr_we = 1'b1;
            pc_en  = 1'b1;
            pc_sel = PC_SEL_REG;
            retire = 1'b1;
          end
          default: state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op == OP_SW);
        if (mem_ack) begin
          pc_en  = 1'b1;
          gpr_we = (op == OP_LW);
          retire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // run is only honoured at an instruction boundary, never mid-instruction
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

`ifdef CPU_SEQ_PERF_EN
  cpu_seq_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .busy_i      (busy),
    .retire_i    (retire),
    .cycle_cnt_o (cycle_cnt),
    .instret_o   (instret)
  );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, reset corner
// case, and a randomized instruction stream against a trace-generating model.
module tb_cpu_sequencer;

  localparam logic [8:0] B  = 9'h100;  // busy
  localparam logic [8:0] RQ = 9'h080;  // mem_req
  localparam logic [8:0] WE = 9'h040;  // mem_we
  localparam logic [8:0] AS = 9'h020;  // mem_addr_sel
  localparam logic [8:0] IR = 9'h010;  // ir_load
  localparam logic [8:0] GW = 9'h008;  // gpr_we
  localparam logic [8:0] PE = 9'h004;  // pc_en
  localparam logic [8:0] S1 = 9'h001;  // pc_sel = 01
  localparam logic [8:0] S2 = 9'h002;  // pc_sel = 10

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic       eq;
    logic       ack;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [2:0] opcode;
  logic       beq_eq;
  logic       mem_ack;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, gpr_we, pc_en, busy;
  logic [1:0] pc_sel;
`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.OPW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .beq_eq       (beq_eq),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .gpr_we       (gpr_we),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
`ifdef CPU_SEQ_PERF_EN
    .cycle_cnt    (cycle_cnt),
    .instret      (instret),
`endif
    .busy         (busy)
  );

  function automatic logic [8:0] outs();
    return {busy, mem_req, mem_we, mem_addr_sel, ir_load, gpr_we, pc_en, pc_sel};
  endfunction

  task automatic check_outs(input logic [8:0] exp, input string tag);
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs {busy,req,we,asel,irl,gwe,pcen,sel}=%b required %b",
               tag, outs(), exp);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, check at the falling edge.
  task automatic cyc(input vec_t v, input string tag);
    run     = v.run;
    opcode  = v.op;
    beq_eq  = v.eq;
    mem_ack = v.ack;
    @(negedge clk);
    check_outs(v.exp, tag);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[28];
  vec_t stream[$];

  function automatic vec_t mk(logic r, logic [2:0] o, logic e, logic a, logic [8:0] x);
    vec_t v;
    v.run = r; v.op = o; v.eq = e; v.ack = a; v.exp = x;
    return v;
  endfunction

  initial begin
    logic parked;
    vec_t v;

    rst = 1'b1; run = 1'b0; opcode = '0; beq_eq = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs('0, "reset_state");
    rst = 1'b0;

    // ALU zero-wait, LW with 3 wait cycles, BEQ taken/not, JALR, SW with run dropped
    tbl[0]  = mk(1, 3'b000, 0, 1, '0);
    tbl[1]  = mk(1, 3'b000, 0, 1, B|RQ|IR);
    tbl[2]  = mk(1, 3'b000, 0, 0, B);
    tbl[3]  = mk(1, 3'b000, 0, 0, B|GW|PE);
    tbl[4]  = mk(1, 3'b000, 0, 1, B|RQ|IR);
    tbl[5]  = mk(1, 3'b101, 0, 0, B);
    tbl[6]  = mk(1, 3'b101, 0, 0, B);
    tbl[7]  = mk(1, 3'b101, 0, 0, B|RQ|AS);
    tbl[8]  = mk(1, 3'b101, 0, 0, B|RQ|AS);
    tbl[9]  = mk(1, 3'b101, 0, 0, B|RQ|AS);
    tbl[10] = mk(1, 3'b101, 0, 1, B|RQ|AS|GW|PE);
    tbl[11] = mk(1, 3'b110, 1, 1, B|RQ|IR);
    tbl[12] = mk(1, 3'b110, 1, 0, B);
    tbl[13] = mk(1, 3'b110, 1, 0, B|PE|S1);
    tbl[14] = mk(1, 3'b110, 0, 1, B|RQ|IR);
    tbl[15] = mk(1, 3'b110, 0, 0, B);
    tbl[16] = mk(1, 3'b110, 0, 0, B|PE);
    tbl[17] = mk(1, 3'b111, 0, 1, B|RQ|IR);
    tbl[18] = mk(1, 3'b111, 0, 0, B);
    tbl[19] = mk(1, 3'b111, 0, 0, B|GW|PE|S2);
    tbl[20] = mk(1, 3'b100, 0, 1, B|RQ|IR);
    tbl[21] = mk(1, 3'b100, 0, 0, B);
    tbl[22] = mk(0, 3'b100, 0, 0, B);
    tbl[23] = mk(0, 3'b100, 0, 0, B|RQ|WE|AS);
    tbl[24] = mk(0, 3'b100, 0, 0, B|RQ|WE|AS);
    tbl[25] = mk(0, 3'b100, 0, 1, B|RQ|WE|AS|PE);
    tbl[26] = mk(0, 3'b100, 0, 1, '0);
    tbl[27] = mk(0, 3'b000, 0, 0, '0);
    for (int i = 0; i < 28; i++) cyc(tbl[i], $sformatf("table[%0d]", i));

    // Reset during a FETCH wait, then a stale ack must not load IR
    cyc(mk(1, 3'b000, 0, 0, '0), "rst_seq_idle");
    cyc(mk(1, 3'b000, 0, 0, B|RQ), "rst_seq_fetch_wait");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs('0, "rst_seq_in_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(mk(0, 3'b000, 0, 1, '0), "rst_seq_late_ack");
    cyc(mk(1, 3'b000, 0, 0, '0), "rst_seq_restart_idle");
    cyc(mk(1, 3'b000, 0, 0, B|RQ), "rst_seq_restart_fetch");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outs('0, "rst_seq_clean");

    // Randomized instruction stream: build the expected cycle trace per instruction
    parked = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op  = 3'($urandom_range(0, 7));
      logic       eq  = 1'($urandom);
      logic       rb  = ($urandom_range(0, 3) != 0);
      int         fd  = $urandom_range(0, 2);
      int         md  = $urandom_range(0, 3);
      logic       mem = (op == 3'b100) || (op == 3'b101);
      logic [8:0] ex;
      $display("instr %0d: op=%b eq=%0d fetch_wait=%0d mem_wait=%0d run_at_end=%0d",
               n, op, eq, fd, md, rb);
      if (parked) begin
        for (int k = 0; k < $urandom_range(0, 2); k++)
          stream.push_back(mk(0, 3'($urandom), 1'($urandom), 1'($urandom), '0));
        stream.push_back(mk(1, 3'($urandom), 1'($urandom), 1'($urandom), '0));
      end
      for (int k = 0; k < fd; k++)
        stream.push_back(mk(1'($urandom), 3'($urandom), 1'($urandom), 0, B|RQ));
      stream.push_back(mk(1'($urandom), 3'($urandom), 1'($urandom), 1, B|RQ|IR));
      stream.push_back(mk(1'($urandom), op, 1'($urandom), 1'($urandom), B));
      if (!mem) begin
        if (op == 3'b110)      ex = B | PE | (eq ? S1 : 9'h0);
        else if (op == 3'b111) ex = B | GW | PE | S2;
        else                   ex = B | GW | PE;
        stream.push_back(mk(rb, op, eq, 1'($urandom), ex));
      end else begin
        stream.push_back(mk(1'($urandom), op, eq, 1'($urandom), B));
        ex = B | RQ | AS | ((op == 3'b100) ? WE : 9'h0);
        for (int k = 0; k < md; k++)
          stream.push_back(mk(1'($urandom), op, 1'($urandom), 0, ex));
        ex = ex | PE | ((op == 3'b101) ? GW : 9'h0);
        stream.push_back(mk(rb, op, 1'($urandom), 1, ex));
      end
      parked = !rb;
    end
    while (stream.size() > 0) begin
      v = stream.pop_front();
      cyc(v, "random");
    end

`ifdef CPU_SEQ_PERF_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (instret !== 32'd0 || cycle_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: instret=%0d cycle_cnt=%0d required 0 and 0", instret, cycle_cnt);
    end
    cyc(mk(1, 3'b000, 0, 0, '0), "perf_idle");
    for (int i = 0; i < 10; i++) begin
      cyc(mk(1, 3'b000, 0, 1, B|RQ|IR), "perf_fetch");
      cyc(mk(1, 3'(i % 4), 0, 0, B), "perf_decode");
      cyc(mk(i < 9, 3'(i % 4), 0, 0, B|GW|PE), "perf_exec");
    end
    n_checks++;
    if (instret !== 32'd10) begin
      n_fail++;
      $display("FAIL perf_instret: got %0d required 10", instret);
    end
    n_checks++;
    if (cycle_cnt !== 32'd30) begin
      n_fail++;
      $display("FAIL perf_cycle_cnt: got %0d required 30", cycle_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
